// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, field positions.
// Optional timer build switch: CP0_TIMER_EN.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int IM_LO        = 10;
  localparam int IP_LO        = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_BD     = 31;

  // A delay-slot victim restarts at the branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    logic [31:0] aligned;
    aligned = pc & 32'hFFFF_FFFC;
    return bd ? aligned - 32'd4 : aligned;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, pending flag raised on Count hitting Compare.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pend
);

  logic [31:0] count_inc;
  logic        load_count;
  logic        load_compare;

  assign count_inc    = count + 32'd1;
  assign load_count   = we && (wa == REG_COUNT);
  assign load_compare = we && (wa == REG_COMPARE);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 32'd0;
      compare <= 32'd0;
      pend    <= 1'b0;
    end else begin
      count <= load_count ? wd : count_inc;
      if (load_compare) begin
        compare <= wd;
      end
      // Software acknowledges the timer by rewriting Compare; that beats a same-cycle hit.
      if (load_compare) begin
        pend <= 1'b0;
      end else if (!load_count && (count_inc == compare)) begin
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_ext.sv
// Coprocessor 0: SR/Cause/EPC/PRId, exception entry/return, masked interrupt request.
// Build with CP0_TIMER_EN to add Count/Compare and a timer interrupt on IP[TIMER_LINE].
module cp0_ext
  import cp0_pkg::*;
#(
  parameter int          N_HWINT    = 6,
  parameter logic [31:0] PRID       = 32'h4255_4141,
  parameter int          TIMER_LINE = 5,
  parameter logic [31:0] EPC_RESET  = 32'h0000_0000
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               WE,
  input  logic [4:0]         WA,
  input  logic [31:0]        WD,
  input  logic [4:0]         RA,
  output logic [31:0]        RD,
  input  logic               ExlSet,
  input  logic               ExlClr,
  input  logic [31:0]        PC,
  input  logic               BD,
  input  logic [4:0]         ExcCode,
  input  logic [N_HWINT-1:0] HWInt,
  output logic               IntReq,
  output logic [31:0]        EPC
);

  logic [N_HWINT-1:0] im;
  logic [N_HWINT-1:0] ip;
  logic [N_HWINT-1:0] hw_eff;
  logic               ie;
  logic               exl;
  logic               cause_bd;
  logic [4:0]         exc_code;
  logic [31:0]        epc_q;
  logic               sr_wr;
  logic               epc_wr;

  assign sr_wr  = WE && (WA == REG_SR);
  assign epc_wr = WE && (WA == REG_EPC);

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_pend;

  cp0_timer u_timer (
    .clk     (Clock),
    .reset   (Reset),
    .we      (WE),
    .wa      (WA),
    .wd      (WD),
    .count   (count),
    .compare (compare),
    .pend    (timer_pend)
  );

  assign hw_eff = HWInt | (N_HWINT'(timer_pend) << TIMER_LINE);
`else
  assign hw_eff = HWInt;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      im       <= '0;
      ip       <= '0;
      ie       <= 1'b0;
      exl      <= 1'b0;
      cause_bd <= 1'b0;
      exc_code <= 5'd0;
      epc_q    <= EPC_RESET;
    end else begin
      ip <= hw_eff;
      if (sr_wr) begin
        im  <= WD[IM_LO +: N_HWINT];
        ie  <= WD[SR_IE];
        exl <= WD[SR_EXL];
      end
      // Exception entry owns EXL/Cause/EPC this cycle; eret and mtc0 only act otherwise.
      if (ExlSet) begin
        exl      <= 1'b1;
        cause_bd <= BD;
        exc_code <= ExcCode;
        epc_q    <= epc_of(PC, BD);
      end else begin
        if (ExlClr) begin
          exl <= 1'b0;
        end
        if (epc_wr) begin
          epc_q <= WD;
        end
      end
    end
  end

  assign IntReq = (|(ip & im)) & ie & ~exl;
  assign EPC    = epc_q;

  always_comb begin
    RD = 32'd0;
    case (RA)
      REG_SR: begin
        RD[IM_LO +: N_HWINT] = im;
        RD[SR_EXL]           = exl;
        RD[SR_IE]            = ie;
      end
      REG_CAUSE: begin
        RD[CAUSE_BD]             = cause_bd;
        RD[IP_LO +: N_HWINT]     = ip;
        RD[CAUSE_EXC_LO +: 5]    = exc_code;
      end
      REG_EPC:     RD = epc_q;
      REG_PRID:    RD = PRID;
`ifdef CP0_TIMER_EN
      REG_COUNT:   RD = count;
      REG_COMPARE: RD = compare;
`endif
      default:     RD = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ext.sv
// Bench for cp0_ext (N_HWINT=3): directed literal checks plus randomized traffic against a behavioural model.
module tb_cp0_ext;

  localparam int          NH   = 3;
  localparam int          TL   = 2;
  localparam logic [31:0] PRV  = 32'h4255_4141;
  localparam logic [31:0] EPCR = 32'hBFC0_0380;

  logic          Clock = 1'b0;
  logic          Reset, WE, ExlSet, ExlClr, BD, IntReq;
  logic [4:0]    WA, RA, ExcCode;
  logic [31:0]   WD, RD, PC, EPC;
  logic [NH-1:0] HWInt;

  int errors = 0;
  int checks = 0;

  cp0_ext #(.N_HWINT(NH), .PRID(PRV), .TIMER_LINE(TL), .EPC_RESET(EPCR)) dut (
    .Clock(Clock), .Reset(Reset), .WE(WE), .WA(WA), .WD(WD), .RA(RA), .RD(RD),
    .ExlSet(ExlSet), .ExlClr(ExlClr), .PC(PC), .BD(BD), .ExcCode(ExcCode),
    .HWInt(HWInt), .IntReq(IntReq), .EPC(EPC)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: architectural register values as plain integers.
  int unsigned m_im, m_ie, m_exl, m_ip, m_bd, m_exc, m_epc, m_count, m_cmp, m_pend;
  bit armed = 0;

  function automatic int unsigned exp_rd(input int unsigned ra);
    case (ra)
      12: return (m_im << 10) | (m_exl << 1) | m_ie;
      13: return (m_bd << 31) | (m_ip << 10) | (m_exc << 2);
      14: return m_epc;
      15: return PRV;
`ifdef CP0_TIMER_EN
      9:  return m_count;
      11: return m_cmp;
`endif
      default: return 0;
    endcase
  endfunction

  always @(posedge Clock) begin
    int unsigned mask, n_im, n_ie, n_exl, n_ip, n_bd, n_exc, n_epc, n_count, n_cmp, n_pend;
    mask = (1 << NH) - 1;
    if (Reset) begin
      m_im = 0; m_ie = 0; m_exl = 0; m_ip = 0; m_bd = 0; m_exc = 0;
      m_epc = EPCR; m_count = 0; m_cmp = 0; m_pend = 0;
      armed = 1;
    end else begin
      n_im = m_im; n_ie = m_ie; n_exl = m_exl; n_bd = m_bd; n_exc = m_exc; n_epc = m_epc;
      n_count = m_count; n_cmp = m_cmp; n_pend = m_pend;
`ifdef CP0_TIMER_EN
      n_ip = (HWInt | (m_pend << TL)) & mask;
      if (WE && WA == 9) n_count = WD;
      else n_count = m_count + 1;
      if (WE && WA == 11) begin
        n_cmp = WD; n_pend = 0;
      end else if (!(WE && WA == 9) && (m_count + 1 == m_cmp)) begin
        n_pend = 1;
      end
`else
      n_ip = HWInt & mask;
`endif
      if (WE && WA == 12) begin
        n_im = (WD >> 10) & mask; n_ie = WD & 1; n_exl = (WD >> 1) & 1;
      end
      if (ExlSet) begin
        n_exl = 1; n_bd = BD; n_exc = ExcCode;
        n_epc = BD ? (PC / 4) * 4 - 4 : (PC / 4) * 4;
      end else begin
        if (ExlClr) n_exl = 0;
        if (WE && WA == 14) n_epc = WD;
      end
      m_im = n_im; m_ie = n_ie; m_exl = n_exl; m_ip = n_ip; m_bd = n_bd; m_exc = n_exc;
      m_epc = n_epc; m_count = n_count; m_cmp = n_cmp; m_pend = n_pend;
    end
  end

  always @(negedge Clock) begin
    if (armed) begin
      chk("model_rd", RD, exp_rd(RA));
      chk("model_intreq", {31'd0, IntReq}, ((m_ip & m_im) != 0 && m_ie == 1 && m_exl == 0) ? 1 : 0);
      chk("model_epc", EPC, m_epc);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    WE = 0; ExlSet = 0; ExlClr = 0;
  endtask

  initial begin
    int hit;
    logic [4:0] wa_set [8];
    wa_set = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd0};
    Reset = 1; WE = 0; WA = 0; WD = 0; RA = 12; ExlSet = 0; ExlClr = 0;
    PC = 0; BD = 0; ExcCode = 0; HWInt = 0;
    tick(); tick();
    @(negedge Clock);
    chk("reset_sr", RD, 32'h0);
    chk("reset_intreq", {31'd0, IntReq}, 32'd0);
    chk("reset_epc", EPC, EPCR);

    // SR write with HWInt[0]; IM bits above line 2 read back as zero.
    tick(); Reset = 0; WE = 1; WA = 12; WD = 32'h0000_FC01; HWInt = 3'b001; RA = 12;
    @(negedge Clock);
    chk("sr_no_bypass", RD, 32'h0);
    tick(); idle();
    @(negedge Clock);
    chk("sr_write", RD, 32'h0000_1C01);
    chk("intreq_on", {31'd0, IntReq}, 32'd1);

    // Exception in a delay slot.
    tick(); ExlSet = 1; PC = 32'h0000_3010; BD = 1; ExcCode = 5'd4; RA = 14;
    tick(); idle();
    @(negedge Clock);
    chk("epc_bd", EPC, 32'h0000_300C);
    chk("rd_epc", RD, 32'h0000_300C);
    chk("intreq_exl", {31'd0, IntReq}, 32'd0);
    tick(); RA = 13;
    @(negedge Clock);
    chk("cause_bd", RD, 32'h8000_0410);

    // Simultaneous set/clear: set wins; then eret alone.
    tick(); ExlSet = 1; ExlClr = 1; PC = 32'h0000_2003; BD = 0; ExcCode = 5'd0; RA = 12;
    tick(); idle();
    @(negedge Clock);
    chk("set_wins", RD, 32'h0000_1C03);
    chk("epc_nobd", EPC, 32'h0000_2000);
    tick(); ExlClr = 1;
    tick(); idle();
    @(negedge Clock);
    chk("eret_sr", RD, 32'h0000_1C01);
    chk("eret_intreq", {31'd0, IntReq}, 32'd1);

    // Top interrupt line of a 3-line build.
    tick(); HWInt = 3'b100; RA = 13;
    tick();
    @(negedge Clock);
    chk("ip_top", RD, 32'h0000_1000);
    chk("intreq_top", {31'd0, IntReq}, 32'd1);

    // SR write together with exception entry.
    tick(); WE = 1; WA = 12; WD = 32'h0; ExlSet = 1; PC = 32'h0000_0100; ExcCode = 5'd12; RA = 12;
    tick(); idle();
    @(negedge Clock);
    chk("sr_exl_forced", RD, 32'h0000_0002);
    tick(); WE = 1; WA = 13; WD = 32'hFFFF_FFFF; RA = 13;
    tick(); WA = 14; WD = 32'h0000_1237;
    @(negedge Clock);
    chk("cause_ro", RD, 32'h0000_1030);
    tick(); idle(); RA = 14;
    @(negedge Clock);
    chk("mtc0_epc", RD, 32'h0000_1237);
    tick(); RA = 15;
    @(negedge Clock);
    chk("prid", RD, PRV);
`ifndef CP0_TIMER_EN
    tick(); RA = 9;
    @(negedge Clock);
    chk("count_absent", RD, 32'h0);
`endif

    // Reset mid-sequence.
    tick(); Reset = 1; RA = 12;
    tick(); Reset = 0; HWInt = 0;
    @(negedge Clock);
    chk("midreset_sr", RD, 32'h0);
    chk("midreset_epc", EPC, EPCR);
    chk("midreset_intreq", {31'd0, IntReq}, 32'd0);

`ifdef CP0_TIMER_EN
    tick(); WE = 1; WA = 11; WD = 32'd10;
    tick(); WA = 9; WD = 32'd0;
    tick(); WA = 12; WD = 32'h0000_1001;
    hit = 0;
    for (int k = 1; k <= 30 && hit == 0; k++) begin
      tick(); idle();
      @(negedge Clock);
      if (IntReq) hit = k;
    end
    chk("timer_latency", hit, 32'd11);
    tick(); WE = 1; WA = 11; WD = 32'h100;
    tick(); idle();
    @(negedge Clock);
    chk("timer_ip_held", {31'd0, IntReq}, 32'd1);
    tick();
    @(negedge Clock);
    chk("timer_cleared", {31'd0, IntReq}, 32'd0);
`endif

    // Randomized traffic, checked every cycle by the model comparator.
    for (int i = 0; i < 3000; i++) begin
      tick();
      Reset   = ($urandom_range(0, 199) == 0);
      WE      = ($urandom_range(0, 2) == 0);
      WA      = wa_set[$urandom_range(0, 7)];
      WD      = $urandom;
      if (WA == 12) WD[1] = ($urandom_range(0, 3) == 0);
      if (WA == 9 || WA == 11) WD = $urandom_range(0, 40);
      RA      = wa_set[$urandom_range(0, 7)];
      ExlSet  = ($urandom_range(0, 9) == 0);
      ExlClr  = ($urandom_range(0, 6) == 0);
      PC      = $urandom;
      BD      = $urandom_range(0, 1);
      ExcCode = 5'($urandom_range(0, 31));
      HWInt   = NH'($urandom);
    end
    tick(); idle(); Reset = 0;
    @(negedge Clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
